// File: rtl/scan_test_controller_pkg.sv
// Shared types and sizing helpers for the scan test controller.
package scan_ctrl_pkg;

  localparam int CHAIN_LEN_DEF = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT_IN,
    S_CAPTURE,
    S_SHIFT_OUT,
    S_DONE
  } scan_state_t;

  // Shift counter must hold 0..len.
  function automatic int cnt_width(input int len);
    return $clog2(len + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_width(CHAIN_LEN_DEF);

endpackage

// File: rtl/scan_test_controller_if.sv
// Pin bundle between the scan controller and the scan-wrapped logic top.
interface scan_test_controller_if;
  logic scan_mode;
  logic scan_in;
  logic scan_clk;
  logic scan_clr;
  logic scan_out;

  modport master (output scan_mode, output scan_in, output scan_clk, output scan_clr, input scan_out);
  modport slave  (input scan_mode, input scan_in, input scan_clk, input scan_clr, output scan_out);
endinterface

// File: rtl/scan_test_controller_shift_reg.sv
// Parallel-load shift register: shifts toward the MSB, serial in at the LSB, serial out from the MSB.
module scan_shift_reg #(
  parameter int CHAIN_LEN = 7
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 load,
  input  logic [CHAIN_LEN-1:0] load_val,
  input  logic                 shift,
  input  logic                 sin,
  output logic [CHAIN_LEN-1:0] q,
  output logic                 sout
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr)        q <= '0;
    else if (load)  q <= load_val;
    else if (shift) q <= {q[CHAIN_LEN-2:0], sin};
  end

  assign sout = q[CHAIN_LEN-1];

endmodule

// File: rtl/scan_test_controller.sv
// Scan chain sequencer: clear, load, optional capture, unload, then compare against an expected vector.
module scan_test_controller
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEF
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   start,
  input  logic                   capture_en,
  input  logic [CHAIN_LEN-1:0]   pattern,
  input  logic [CHAIN_LEN-1:0]   expected,
  scan_test_controller_if.master chain,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [CHAIN_LEN-1:0]   mismatch,
  output logic [CHAIN_LEN-1:0]   captured
);

  localparam int CNT_W = cnt_width(CHAIN_LEN);

  scan_state_t          state, state_n;
  logic                 phase, phase_n;   // 0 = SETUP, 1 = PULSE
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic                 cap_en_q;
  logic [CHAIN_LEN-1:0] exp_q;
  logic                 mode_q, sclk_q, sclr_q, sin_q;
  logic                 mode_n, sclk_n, sclr_n, sin_n, busy_n, done_n;
  logic                 ser_shift, ser_msb, cap_shift;
  logic                 accept, last_shift;
  logic [CHAIN_LEN-1:0] ser_q_unused;
  logic                 cap_sout_unused;

  assign accept     = (state == S_IDLE) && start;
  assign last_shift = (cnt == CNT_W'(CHAIN_LEN - 1));
  // scan_out is sampled at the edge closing SETUP, i.e. before that shift's scan_clk rise.
  assign cap_shift  = (state == S_SHIFT_OUT) && !phase;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= S_IDLE;
      phase  <= 1'b0;
      cnt    <= '0;
      mode_q <= 1'b0;
      sclk_q <= 1'b0;
      sclr_q <= 1'b1;
      sin_q  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      phase  <= phase_n;
      cnt    <= cnt_n;
      mode_q <= mode_n;
      sclk_q <= sclk_n;
      sclr_q <= sclr_n;
      sin_q  <= sin_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    phase_n = phase;
    cnt_n   = cnt;
    case (state)
      S_IDLE:  if (start) state_n = S_CLEAR;
      S_CLEAR: begin
        state_n = S_SHIFT_IN;
        phase_n = 1'b0;
        cnt_n   = '0;
      end
      S_SHIFT_IN, S_SHIFT_OUT: begin
        phase_n = ~phase;
        if (phase) begin
          if (last_shift) begin
            cnt_n = '0;
            if (state == S_SHIFT_OUT) state_n = S_DONE;
            else                      state_n = cap_en_q ? S_CAPTURE : S_SHIFT_OUT;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      S_CAPTURE: begin
        phase_n = ~phase;
        if (phase) state_n = S_SHIFT_OUT;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are derived from the next state so every pin is a flop with a full period of setup.
  always_comb begin
    mode_n    = 1'b0;
    sclk_n    = 1'b0;
    sclr_n    = 1'b0;
    sin_n     = 1'b0;
    ser_shift = 1'b0;
    busy_n    = (state_n != S_IDLE);
    done_n    = (state_n == S_DONE);
    case (state_n)
      S_CLEAR: sclr_n = 1'b1;
      S_SHIFT_IN: begin
        mode_n = 1'b1;
        sclk_n = phase_n;
        if (phase_n) begin
          sin_n = sin_q;
        end else begin
          sin_n     = ser_msb;
          ser_shift = 1'b1;
        end
      end
      S_CAPTURE:   sclk_n = phase_n;
      S_SHIFT_OUT: begin
        mode_n = 1'b1;
        sclk_n = phase_n;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cap_en_q <= 1'b0;
      pass     <= 1'b0;
      mismatch <= '0;
    end else if (accept) begin
      cap_en_q <= capture_en;
      pass     <= 1'b0;
      mismatch <= '0;
    end else if (state_n == S_DONE) begin
      pass     <= (captured == exp_q);
      mismatch <= captured ^ exp_q;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) exp_q <= expected;
  end

  scan_shift_reg #(.CHAIN_LEN(CHAIN_LEN)) u_ser (
    .clk      (clk),
    .clr      (clr),
    .load     (accept),
    .load_val (pattern),
    .shift    (ser_shift),
    .sin      (1'b0),
    .q        (ser_q_unused),
    .sout     (ser_msb)
  );

  scan_shift_reg #(.CHAIN_LEN(CHAIN_LEN)) u_cap (
    .clk      (clk),
    .clr      (clr),
    .load     (accept),
    .load_val ('0),
    .shift    (cap_shift),
    .sin      (chain.scan_out),
    .q        (captured),
    .sout     (cap_sout_unused)
  );

  assign chain.scan_mode = mode_q;
  assign chain.scan_in   = sin_q;
  assign chain.scan_clk  = sclk_q;
  assign chain.scan_clr  = sclr_q;

endmodule

// File: tb/tb_scan_test_controller.sv
// Bench for scan_test_controller against a 7-flop chain model with a programmable capture value.
module tb_scan_test_controller;

  localparam int N = 7;

  typedef struct {
    int           done_cyc;
    int           rises;
    logic [N-1:0] captured;
    logic [N-1:0] mismatch;
    logic         pass;
  } exp_t;

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic         start = 1'b0;
  logic         capture_en = 1'b0;
  logic [N-1:0] pattern = '0;
  logic [N-1:0] expected = '0;
  logic         busy, done, pass;
  logic [N-1:0] mismatch, captured;

  logic [N-1:0] chain_q = '0;
  logic [N-1:0] cap_val = '0;
  logic         stuck = 1'b0;
  int           rises = 0;
  int           n_vec = 0;
  int           n_mis = 0;
  exp_t         sb[$];

  scan_test_controller_if chain();

  scan_test_controller #(.CHAIN_LEN(N)) dut (
    .clk        (clk),
    .clr        (clr),
    .start      (start),
    .capture_en (capture_en),
    .pattern    (pattern),
    .expected   (expected),
    .chain      (chain),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .mismatch   (mismatch),
    .captured   (captured)
  );

  always #5 clk = ~clk;

  // Chain model: position 0 next to scan_in, position N-1 drives scan_out.
  always @(posedge chain.scan_clk or posedge chain.scan_clr) begin
    if (chain.scan_clr)      chain_q <= '0;
    else if (chain.scan_mode) chain_q <= {chain_q[N-2:0], chain.scan_in};
    else                      chain_q <= cap_val;
  end
  assign chain.scan_out = stuck ? 1'b0 : chain_q[N-1];

  always @(posedge chain.scan_clk) rises <= rises + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge following done.
  task automatic run_test(input string name, input logic cen, input logic [N-1:0] pat,
                          input logic [N-1:0] expv, input logic [N-1:0] capv,
                          input logic stk, input int poke);
    exp_t         e;
    exp_t         got_e;
    int           c;
    int           base;
    logic [N-1:0] cm;
    cm         = stk ? '0 : (cen ? capv : pat);
    e.done_cyc = cen ? 4 * N + 4 : 4 * N + 2;
    e.rises    = cen ? 2 * N + 1 : 2 * N;
    e.captured = cm;
    e.mismatch = cm ^ expv;
    e.pass     = (cm == expv);
    sb.push_back(e);

    cap_val    = capv;
    stuck      = stk;
    pattern    = pat;
    expected   = expv;
    capture_en = cen;
    base       = rises;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 1;
    check({name, "_c1_scan_clr"}, chain.scan_clr, 1);
    check({name, "_c1_busy"}, busy, 1);
    check({name, "_c1_captured"}, captured, 0);
    check({name, "_c1_pass"}, pass, 0);
    while (!done && c < 100) begin
      @(posedge clk); #1;
      c++;
      if (c == 2) check({name, "_c2_mode"}, chain.scan_mode, 1);
      if (cen && (c == 2 * N + 2 || c == 2 * N + 3)) check({name, "_cap_mode"}, chain.scan_mode, 0);
      start = (c == poke);
    end
    check({name, "_done_seen"}, done, 1);

    got_e = sb.pop_front();
    check({name, "_done_cycle"}, c, got_e.done_cyc);
    check({name, "_rises"}, rises - base, got_e.rises);
    check({name, "_captured"}, captured, got_e.captured);
    check({name, "_mismatch"}, mismatch, got_e.mismatch);
    check({name, "_pass"}, pass, got_e.pass);

    @(posedge clk); #1;
    start = 1'b0;
    check({name, "_after_done"}, done, 0);
    check({name, "_after_busy"}, busy, 0);
    check({name, "_held_pass"}, pass, got_e.pass);
    check({name, "_held_captured"}, captured, got_e.captured);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_scan_clr", chain.scan_clr, 1);
    check("rst_scan_mode", chain.scan_mode, 0);
    check("rst_scan_clk", chain.scan_clk, 0);
    check("rst_scan_in", chain.scan_in, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_mismatch", mismatch, 0);
    check("rst_captured", captured, 0);
    @(negedge clk);
    clr = 1'b0;
    #1;
    check("rst_clr_held", chain.scan_clr, 1);
    @(posedge clk); #1;
    check("rst_clr_dropped", chain.scan_clr, 0);

    run_test("integ",    1'b0, 7'b1011001, 7'b1011001, 7'b0000000, 1'b0, 0);
    run_test("cap_pass", 1'b1, 7'b0101010, 7'b1110000, 7'b1110000, 1'b0, 5);
    run_test("cap_fail", 1'b1, 7'b0101010, 7'b1110001, 7'b1110000, 1'b0, 4 * N + 4);
    run_test("stuck",    1'b0, 7'h7F,      7'h7F,      7'b0000000, 1'b1, 0);

    // Abort: start during SHIFT_IN must be ignored, then clr mid-test.
    pattern    = 7'h55;
    expected   = 7'h55;
    capture_en = 1'b0;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("abort_ign_scan_clr", chain.scan_clr, 0);
    check("abort_ign_mode", chain.scan_mode, 1);
    check("abort_ign_busy", busy, 1);
    @(posedge clk); #1;
    clr = 1'b1;
    #1;
    check("abort_scan_clr", chain.scan_clr, 1);
    check("abort_scan_mode", chain.scan_mode, 0);
    check("abort_scan_clk", chain.scan_clk, 0);
    check("abort_scan_in", chain.scan_in, 0);
    check("abort_busy", busy, 0);
    check("abort_captured", captured, 0);
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk); #1;
    check("abort_clr_dropped", chain.scan_clr, 0);

    run_test("post_abort", 1'b1, 7'b0011100, 7'b1110000, 7'b1110000, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/scan_test_controller.md
# scan_test_controller

Sequencer that drives a single scan chain through clear, load, capture and unload, then compares the unloaded bits against an expected vector. It sits directly upstream of the scan-wrapped logic top and drives that top's ScanMode, ScanIn, ScanClk and ScanClr pins. It consumes the top's ScanOut and reports pass/fail plus a per-bit mismatch map.

## Interface
- CHAIN_LEN, 7, number of flops in the chain (4 input + 3 output cells); legal range 2..32.
- clk  in  1  system clock; all outputs are registered on its rising edge.
- clr  in  1  reset, asynchronous, active-high.
- start  in  1  request one test; sampled only in IDLE.
- capture_en  in  1  sampled with start; 0 skips CAPTURE (chain-integrity test).
- pattern  in  CHAIN_LEN  load vector; pattern[k] is destined for chain position k (k=0 is nearest scan_in); sampled with start.
- expected  in  CHAIN_LEN  compare vector, same bit mapping as pattern; sampled with start.
- scan_out  in  1  serial return from the last chain flop.
- scan_mode  out  1  1 = chain shifts; 0 = functional/capture.
- scan_in  out  1  serial data into chain position 0.
- scan_clk  out  1  chain clock; each rising edge is one shift or capture.
- scan_clr  out  1  chain clear.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- done  out  1  one-cycle pulse at end of test.
- pass  out  1  (captured == expected); valid from done, held until the next start.
- mismatch  out  CHAIN_LEN  captured ^ expected; held like pass.
- captured  out  CHAIN_LEN  unloaded vector, same bit mapping; held like pass.

## Operation
- States: IDLE, CLEAR, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE.
- IDLE -> CLEAR when start=1. Latch pattern, expected and capture_en; clear pass, mismatch and captured.
- CLEAR: one cycle with scan_clr=1 and scan_mode=0, then go to SHIFT_IN.
- Each shift is two cycles:
  - SETUP: scan_clk=0; scan_in is driven; scan_out is sampled.
  - PULSE: scan_clk=1.
- SHIFT_IN:
  - scan_mode=1 for CHAIN_LEN shifts.
  - Bit order pattern[CHAIN_LEN-1] first, pattern[0] last.
  - Exit to CAPTURE if capture_en, else to SHIFT_OUT.
- CAPTURE:
  - scan_mode=0 for SETUP (one cycle for the functional paths to settle), then one PULSE.
  - Go to SHIFT_OUT.
- SHIFT_OUT:
  - scan_mode=1 for CHAIN_LEN shifts; scan_in=0.
  - The scan_out sample in shift j (j=0..CHAIN_LEN-1) is written to captured[CHAIN_LEN-1-j].
  - The sample is taken in SETUP, before that shift's PULSE.
- DONE: done=1; pass and mismatch are updated; go to IDLE.
- start is ignored outside IDLE. A start coincident with DONE is ignored.
- scan_mode=0 in IDLE, CLEAR and DONE.

## Timing
- Reset values:
  - scan_clr=1, which holds the chain clear while the controller is in reset.
  - scan_mode=0, scan_in=0, scan_clk=0.
  - busy=0, done=0, pass=0, mismatch=0, captured=0.
  - State is IDLE.
- scan_clr drops to 0 on the first clk edge after clr deasserts.
- clr mid-test aborts immediately. Outputs take reset values; the next start runs the full sequence.
- scan_in and scan_mode change only in SETUP, or on state entry with scan_clk=0. This gives one full clk period of setup before each scan_clk rise.
- With start sampled at edge 0:
  - CLEAR is cycle 1.
  - SHIFT_IN is cycles 2..2N+1.
  - CAPTURE is cycles 2N+2..2N+3.
  - SHIFT_OUT is cycles 2N+4..4N+3.
  - done occurs in cycle 4N+4 (32 for N=7).
  - Without capture, done occurs in cycle 4N+2 (30).
- scan_clk rising edges per test: 2N+1 with capture, 2N without.

## Structure
- Package scan_ctrl_pkg holds:
  - the state enum scan_state_t;
  - the CHAIN_LEN default constant;
  - localparam helpers for the shift counter width, $clog2(CHAIN_LEN+1).
- One sub-module, scan_shift_reg: a CHAIN_LEN-bit register with parallel load, MSB serial out and LSB serial in.
  - One instance serialises pattern.
  - A second instance assembles captured.
- FSM, phase toggle and shift counter stay in the top.

## Test plan
- Reset:
  - Stimulus: clr=1 at any point.
  - Response: scan_clr=1, scan_mode=0, scan_clk=0, busy=0, done=0, pass=0, mismatch=0; scan_clr=0 one edge after release.
- Integrity:
  - Stimulus: N=7 shift-register chain model, capture_en=0, pattern=expected=7'b1011001.
  - Response: done in cycle 30, captured=7'b1011001, pass=1, mismatch=0, exactly 14 scan_clk rises.
- Capture pass:
  - Stimulus: chain model whose capture loads 7'b1110000, capture_en=1, expected=7'b1110000.
  - Response: done in cycle 32, pass=1, 15 scan_clk rises, scan_mode=0 during both CAPTURE cycles.
- Capture fail:
  - Stimulus: same model, expected=7'b1110001.
  - Response: pass=0, mismatch=7'b0000001, captured=7'b1110000.
- Stuck-at fault:
  - Stimulus: scan_out tied 0, pattern=expected=7'h7F, capture_en=0.
  - Response: captured=0, mismatch=7'h7F, pass=0.
- Abort and ignore:
  - Stimulus: start pulsed during SHIFT_IN, then clr pulsed at cycle 5.
  - Response: the start during SHIFT_IN is ignored. clr forces all outputs to reset values at once, including scan_clr=1. A following start completes normally with done in cycle 30 or 32 after it.
